// File: rtl/riscv_pkg.sv
// Shared RISC-V core package: NOP encoding, major opcodes, fetch FSM states.
package riscv_pkg;

  // addi x0, x0, 0 : carried by every IF/ID bubble
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  localparam logic [6:0] R_TYPE = 7'b0110011;
  localparam logic [6:0] LW     = 7'b0000011;
  localparam logic [6:0] SW     = 7'b0100011;
  localparam logic [6:0] BR     = 7'b1100011;
  localparam logic [6:0] I_TYPE = 7'b0010011;
  localparam logic [6:0] J      = 7'b1101111;
  localparam logic [6:0] JR     = 7'b1100111;
  localparam logic [6:0] HALT   = 7'b1111111;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/fetch_perf_ctr.sv
// Fetch performance counters: fetched-cycle and stalled-cycle event counts.
// Only instantiated when FETCH_PERF_CNT_EN is defined.
module fetch_perf_ctr (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_evt_i,
  input  logic        stall_evt_i,
  output logic [31:0] fetch_cnt_o,
  output logic [31:0] stall_cnt_o
);

  logic [31:0] r_fetch_cnt;
  logic [31:0] r_stall_cnt;

  // Count events; both counters wrap naturally at 2^32
  always_ff @(posedge clk) begin
    if (reset) begin
      r_fetch_cnt <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (fetch_evt_i) r_fetch_cnt <= r_fetch_cnt + 32'd1;
      if (stall_evt_i) r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign fetch_cnt_o = r_fetch_cnt;
  assign stall_cnt_o = r_stall_cnt;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register.
// Optional feature macro: FETCH_PERF_CNT_EN (adds fetch/stall cycle counters).
//
// IF/ID handshake: ifid_valid_o=1 means IF/ID holds a real instruction for the
// decoder; ifid_valid_o=0 is a bubble carrying NOP_INST. stall_i acts as
// "downstream not ready": while it is high (and no redirect/halt wins) every
// IF/ID field and the PC hold, so no word is lost or duplicated.
module fetch_stage
  import riscv_pkg::*;
#(
  parameter int              PC_W     = 9,
  parameter int              INST_W   = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall_i,
  input  logic              redirect_i,
  input  logic [PC_W-1:0]   redirect_pc_i,
  input  logic              halt_i,
  output logic [PC_W-1:0]   imem_addr_o,
  input  logic [INST_W-1:0] imem_rdata_i,
  output logic [PC_W-1:0]   ifid_pc_o,
  output logic [INST_W-1:0] ifid_inst_o,
  output logic [6:0]        ifid_opcode_o,
  output logic              ifid_valid_o,
  output logic              halted_o,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0]       fetch_cnt_o,
  output logic [31:0]       stall_cnt_o,
`endif
  output fetch_state_e      dbg_state_o
);

  localparam logic [INST_W-1:0] BUBBLE = INST_W'(NOP_INST);

  fetch_state_e      r_state,      w_state_nxt;
  logic [PC_W-1:0]   r_pc,         w_pc_nxt;
  logic [PC_W-1:0]   r_ifid_pc,    w_ifid_pc_nxt;
  logic [INST_W-1:0] r_ifid_inst,  w_ifid_inst_nxt;
  logic              r_ifid_valid, w_ifid_valid_nxt;
  logic [PC_W-1:0]   w_redirect_pc;
  logic              w_halt_take;

  // Targets are word aligned; low two bits are dropped
  assign w_redirect_pc = redirect_pc_i & ~PC_W'(3);
  // Only a real instruction in ID can halt, and a redirect squashes it
  assign w_halt_take   = halt_i & r_ifid_valid & ~redirect_i;

  // Next-state and datapath selection; priority redirect > halt > stall > fetch
  always_comb begin
    w_state_nxt      = r_state;
    w_pc_nxt         = r_pc;
    w_ifid_pc_nxt    = r_ifid_pc;
    w_ifid_inst_nxt  = r_ifid_inst;
    w_ifid_valid_nxt = r_ifid_valid;
    case (r_state)
      RUN: begin
        if (redirect_i) begin
          w_pc_nxt         = w_redirect_pc;
          w_ifid_inst_nxt  = BUBBLE;
          w_ifid_valid_nxt = 1'b0;
        end else if (w_halt_take) begin
          w_ifid_inst_nxt  = BUBBLE;
          w_ifid_valid_nxt = 1'b0;
          w_state_nxt      = HALTED;
        end else if (stall_i) begin
          // hold everything
        end else begin
          w_ifid_pc_nxt    = r_pc;
          w_ifid_inst_nxt  = imem_rdata_i;
          w_ifid_valid_nxt = 1'b1;
          w_pc_nxt         = r_pc + PC_W'(4);
        end
      end
      HALTED: begin
        // frozen until reset
      end
      default: w_state_nxt = RUN;
    endcase
  end

  // State and pipeline registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= RUN;
      r_pc         <= RESET_PC;
      r_ifid_pc    <= '0;
      r_ifid_inst  <= BUBBLE;
      r_ifid_valid <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_pc         <= w_pc_nxt;
      r_ifid_pc    <= w_ifid_pc_nxt;
      r_ifid_inst  <= w_ifid_inst_nxt;
      r_ifid_valid <= w_ifid_valid_nxt;
    end
  end

  assign imem_addr_o   = r_pc;
  assign ifid_pc_o     = r_ifid_pc;
  assign ifid_inst_o   = r_ifid_inst;
  assign ifid_opcode_o = r_ifid_inst[6:0];
  assign ifid_valid_o  = r_ifid_valid;
  assign halted_o      = (r_state == HALTED);
  assign dbg_state_o   = r_state;

`ifdef FETCH_PERF_CNT_EN
  logic w_fetch_evt;
  logic w_stall_evt;

  assign w_stall_evt = (r_state == RUN) & ~redirect_i & ~w_halt_take & stall_i;
  assign w_fetch_evt = (r_state == RUN) & ~redirect_i & ~w_halt_take & ~stall_i;

  fetch_perf_ctr u_perf (
    .clk         (clk),
    .reset       (reset),
    .fetch_evt_i (w_fetch_evt),
    .stall_evt_i (w_stall_evt),
    .fetch_cnt_o (fetch_cnt_o),
    .stall_cnt_o (stall_cnt_o)
  );
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed table-driven bench for fetch_stage (PC_W=9, RESET_PC=0).
// Build with +define+FETCH_PERF_CNT_EN to also check the counters.
module tb_fetch_stage;
  import riscv_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic        stall_i = 1'b0;
  logic        redirect_i = 1'b0;
  logic [8:0]  redirect_pc_i = '0;
  logic        halt_i = 1'b0;
  logic [8:0]  imem_addr_o;
  logic [31:0] imem_rdata_i;
  logic [8:0]  ifid_pc_o;
  logic [31:0] ifid_inst_o;
  logic [6:0]  ifid_opcode_o;
  logic        ifid_valid_o;
  logic        halted_o;
  fetch_state_e dbg_state_o;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_o;
  logic [31:0] stall_cnt_o;
`endif

  fetch_stage #(.PC_W(9), .INST_W(32), .RESET_PC(9'h000)) dut (
    .clk           (clk),
    .reset         (reset),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .halt_i        (halt_i),
    .imem_addr_o   (imem_addr_o),
    .imem_rdata_i  (imem_rdata_i),
    .ifid_pc_o     (ifid_pc_o),
    .ifid_inst_o   (ifid_inst_o),
    .ifid_opcode_o (ifid_opcode_o),
    .ifid_valid_o  (ifid_valid_o),
    .halted_o      (halted_o),
`ifdef FETCH_PERF_CNT_EN
    .fetch_cnt_o   (fetch_cnt_o),
    .stall_cnt_o   (stall_cnt_o),
`endif
    .dbg_state_o   (dbg_state_o)
  );

  // Address-tagged instruction memory
  function automatic logic [31:0] word_at(input logic [8:0] a);
    return 32'hC000_0000 | {23'd0, a};
  endfunction
  assign imem_rdata_i = word_at(imem_addr_o);

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act);
    logic [31:0] e;
    e = exp_q.pop_front();
    total++;
    if (act !== e) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, e, $time);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       rst;
    logic       stl;
    logic       rdr;
    logic [8:0] rpc;
    logic       hlt;
    logic [8:0] e_pc;
    logic [8:0] e_ifpc;
    logic       e_v;
    logic       e_h;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic rst, input logic stl, input logic rdr, input logic [8:0] rpc,
                     input logic hlt, input logic [8:0] e_pc, input logic [8:0] e_ifpc,
                     input logic e_v, input logic e_h);
    vec_t v;
    v.rst = rst; v.stl = stl; v.rdr = rdr; v.rpc = rpc; v.hlt = hlt;
    v.e_pc = e_pc; v.e_ifpc = e_ifpc; v.e_v = e_v; v.e_h = e_h;
    tbl.push_back(v);
  endtask

  // ---------------- driver ----------------
  task automatic drive(input vec_t v);
    reset = v.rst; stall_i = v.stl; redirect_i = v.rdr;
    redirect_pc_i = v.rpc; halt_i = v.hlt;
    @(posedge clk);
    #1;
  endtask

  task automatic check_row(input int i, input vec_t v);
    logic [31:0] e_inst;
    e_inst = v.e_v ? word_at(v.e_ifpc) : NOP_INST;
    exp_q.push_back({23'd0, v.e_pc});   chk($sformatf("r%0d imem_addr", i), {23'd0, imem_addr_o});
    exp_q.push_back({31'd0, v.e_v});    chk($sformatf("r%0d ifid_valid", i), {31'd0, ifid_valid_o});
    exp_q.push_back(e_inst);            chk($sformatf("r%0d ifid_inst", i), ifid_inst_o);
    exp_q.push_back({25'd0, e_inst[6:0]}); chk($sformatf("r%0d opcode", i), {25'd0, ifid_opcode_o});
    exp_q.push_back({31'd0, v.e_h});    chk($sformatf("r%0d halted", i), {31'd0, halted_o});
    exp_q.push_back({31'd0, v.e_h});    chk($sformatf("r%0d state", i), {31'd0, dbg_state_o});
    if (v.e_v) begin
      exp_q.push_back({23'd0, v.e_ifpc}); chk($sformatf("r%0d ifid_pc", i), {23'd0, ifid_pc_o});
    end
  endtask

  initial begin
    int n;
    //   rst  stl  rdr  rpc     hlt  e_pc    e_ifpc  e_v  e_h
    add(1'b1,1'b0,1'b0,9'h000,1'b0,9'h000,9'h000,1'b0,1'b0); // 0 reset
    add(1'b0,1'b0,1'b0,9'h000,1'b0,9'h004,9'h000,1'b1,1'b0); // 1 fetch
    add(1'b0,1'b0,1'b0,9'h000,1'b0,9'h008,9'h004,1'b1,1'b0); // 2
    add(1'b0,1'b1,1'b0,9'h000,1'b0,9'h008,9'h004,1'b1,1'b0); // 3 stall
    add(1'b0,1'b1,1'b0,9'h000,1'b0,9'h008,9'h004,1'b1,1'b0); // 4 stall
    add(1'b0,1'b1,1'b0,9'h000,1'b0,9'h008,9'h004,1'b1,1'b0); // 5 stall
    add(1'b0,1'b0,1'b0,9'h000,1'b0,9'h00C,9'h008,1'b1,1'b0); // 6 resume
    add(1'b0,1'b0,1'b0,9'h000,1'b0,9'h010,9'h00C,1'b1,1'b0); // 7
    add(1'b0,1'b1,1'b1,9'h043,1'b0,9'h040,9'h000,1'b0,1'b0); // 8 redirect beats stall
    add(1'b0,1'b0,1'b0,9'h000,1'b0,9'h044,9'h040,1'b1,1'b0); // 9 target word
    add(1'b0,1'b0,1'b1,9'h080,1'b1,9'h080,9'h000,1'b0,1'b0); // 10 redirect beats halt
    add(1'b0,1'b0,1'b0,9'h000,1'b1,9'h084,9'h080,1'b1,1'b0); // 11 halt on bubble ignored
    add(1'b0,1'b0,1'b0,9'h000,1'b0,9'h088,9'h084,1'b1,1'b0); // 12
    add(1'b0,1'b1,1'b0,9'h000,1'b1,9'h088,9'h000,1'b0,1'b1); // 13 halt beats stall
    add(1'b0,1'b1,1'b1,9'h010,1'b0,9'h088,9'h000,1'b0,1'b1); // 14 halted: ignore
    add(1'b0,1'b0,1'b0,9'h000,1'b1,9'h088,9'h000,1'b0,1'b1); // 15 halted: frozen
    add(1'b1,1'b0,1'b0,9'h000,1'b0,9'h000,9'h000,1'b0,1'b0); // 16 reset leaves HALTED
    add(1'b0,1'b0,1'b1,9'h1FF,1'b0,9'h1FC,9'h000,1'b0,1'b0); // 17 redirect to 0x1FC
    add(1'b0,1'b0,1'b0,9'h000,1'b0,9'h000,9'h1FC,1'b1,1'b0); // 18 wrap
    add(1'b0,1'b0,1'b0,9'h000,1'b0,9'h004,9'h000,1'b1,1'b0); // 19
    add(1'b1,1'b1,1'b1,9'h0F0,1'b1,9'h000,9'h000,1'b0,1'b0); // 20 reset wins all

    #1;
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i]);
      check_row(i, tbl[i]);
`ifdef FETCH_PERF_CNT_EN
      if (i == 15) begin
        exp_q.push_back(32'd7); chk("fetch_cnt_s1_4", fetch_cnt_o);
        exp_q.push_back(32'd3); chk("stall_cnt_s1_4", stall_cnt_o);
      end
      if (i == 20) begin
        exp_q.push_back(32'd0); chk("fetch_cnt_rst", fetch_cnt_o);
        exp_q.push_back(32'd0); chk("stall_cnt_rst", stall_cnt_o);
      end
`endif
    end

    // Held halt from reset: bubble ignores it, first valid word halts (2 edges)
    reset = 1'b0; stall_i = 1'b0; redirect_i = 1'b0; halt_i = 1'b1;
    n = 0;
    while (!halted_o && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    exp_q.push_back(32'd2);   chk("halt_latency", n);
    exp_q.push_back(32'h004); chk("halt_pc", {23'd0, imem_addr_o});
    exp_q.push_back(32'd0);   chk("halt_valid", {31'd0, ifid_valid_o});
`ifdef FETCH_PERF_CNT_EN
    exp_q.push_back(32'd1);   chk("fetch_cnt_halt", fetch_cnt_o);
    exp_q.push_back(32'd0);   chk("stall_cnt_halt", stall_cnt_o);
`endif
    // Frozen for several more cycles despite stimulus
    redirect_i = 1'b1; redirect_pc_i = 9'h100; stall_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    exp_q.push_back(32'h004); chk("frozen_pc", {23'd0, imem_addr_o});
    exp_q.push_back(32'd1);   chk("frozen_halted", {31'd0, halted_o});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog
  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
